// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
//   op_e    : operation codes (110/111 are illegal, handled as PASS + err)
//   state_e : control FSM states
//   clog2   : constant-width helper for derived parameters
package shift_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'(OP_ROR));
    endfunction

endpackage

// File: rtl/shift_amt_mux.sv
// Shift-amount channel select, purely combinational.
//   amt_ch  : NSRC packed amounts, channel i at [i*AMT_W +: AMT_W]
//   amt_sel : channel select; any value >= NSRC saturates to channel NSRC-1
//   amt     : selected amount
module shift_amt_mux #(
    parameter int NSRC  = 3,
    parameter int AMT_W = 5,
    parameter int SEL_W = 2
) (
    input  logic [NSRC*AMT_W-1:0] amt_ch,
    input  logic [SEL_W-1:0]      amt_sel,
    output logic [AMT_W-1:0]      amt
);
    import shift_pkg::*;

    // Start from the top channel so out-of-range selects fall through to it.
    always_comb begin
        amt = amt_ch[(NSRC-1)*AMT_W +: AMT_W];
        for (int i = 0; i < NSRC - 1; i++) begin
            if (amt_sel == SEL_W'(i)) amt = amt_ch[i*AMT_W +: AMT_W];
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit: selects an amount from one of NSRC channels and
// shifts a WIDTH-bit operand BPC bits per cycle (logical/arith/rotate).
//   clk, reset_n : clock (rising edge), async active-low reset
//   start        : request, accepted only while busy=0
//   op           : operation code, sampled with start
//   data_in      : operand, sampled with start
//   amt_ch       : packed amount channels
//   amt_sel      : amount channel select, sampled with start
//   busy         : high in SHIFT and DONE
//   done         : one-cycle pulse, result valid
//   result       : registered result, held until the next done
//   err          : pulses with done when the op was illegal
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 3,
    parameter  int BPC   = 1,
    localparam int AMT_W = clog2(WIDTH),
    localparam int SEL_W = clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [NSRC*AMT_W-1:0] amt_ch,
    input  logic [SEL_W-1:0]      amt_sel,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  err
);

    localparam logic [AMT_W:0]   WIDTH_L = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W-1:0] BPC_L   = AMT_W'(BPC);

    state_e           state;
    op_e              cop;
    logic [WIDTH-1:0] working;
    logic [AMT_W-1:0] rem;

    logic [AMT_W-1:0] sel_amt;
    logic [AMT_W-1:0] eff_amt;
    logic             legal;
    logic [AMT_W-1:0] step;
    logic [AMT_W:0]   rot_back;
    logic [WIDTH-1:0] stepped;

    shift_amt_mux #(
        .NSRC  (NSRC),
        .AMT_W (AMT_W),
        .SEL_W (SEL_W)
    ) u_amt_mux (
        .amt_ch  (amt_ch),
        .amt_sel (amt_sel),
        .amt     (sel_amt)
    );

    // PASS and illegal ops never shift, so they go straight to DONE.
    assign legal   = op_legal(op);
    assign eff_amt = (!legal || op == 3'(OP_PASS)) ? '0 : sel_amt;

    // Last step may be shorter than BPC.
    assign step     = (rem > BPC_L) ? BPC_L : rem;
    assign rot_back = WIDTH_L - {1'b0, step};

    always_comb begin
        stepped = working;
        case (cop)
            OP_SLL:  stepped = working << step;
            OP_SRL:  stepped = working >> step;
            OP_SRA:  stepped = $signed(working) >>> step;
            OP_ROL:  stepped = (working << step) | (working >> rot_back);
            OP_ROR:  stepped = (working >> step) | (working << rot_back);
            default: stepped = working;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cop     <= OP_PASS;
            working <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        working <= data_in;
                        rem     <= eff_amt;
                        cop     <= legal ? op_e'(op) : OP_PASS;
                        busy    <= 1'b1;
                        if (eff_amt == '0) begin
                            state  <= ST_DONE;
                            result <= data_in;
                            done   <= 1'b1;
                            err    <= !legal;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    working <= stepped;
                    rem     <= rem - step;
                    if (rem == step) begin
                        state  <= ST_DONE;
                        result <= stepped;
                        done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        op = '0;
    logic [W-1:0]      data_in = '0;
    logic [N*AW-1:0]   amt_ch = '0;
    logic [SW-1:0]     amt_sel = '0;

    logic         busy1, done1, err1, busy4, done4, err4;
    logic [W-1:0] res1, res4;

    iter_shift_unit #(.WIDTH(W), .NSRC(N), .BPC(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .data_in(data_in),
        .amt_ch(amt_ch), .amt_sel(amt_sel), .busy(busy1), .done(done1),
        .result(res1), .err(err1));

    iter_shift_unit #(.WIDTH(W), .NSRC(N), .BPC(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .data_in(data_in),
        .amt_ch(amt_ch), .amt_sel(amt_sel), .busy(busy4), .done(done4),
        .result(res4), .err(err4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           at;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Whole-amount reference: one shift by the full amount.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] d, input int a);
        logic [2*W-1:0] dd;
        dd = {d, d};
        case (o)
            3'd1: return d << a;
            3'd2: return d >> a;
            3'd3: return $signed(d) >>> a;
            3'd4: return dd[2*W-1-a -: W];
            3'd5: return dd[a +: W];
            default: return d;
        endcase
    endfunction

    function automatic int lat(input int a, input int bpc);
        return (a + bpc - 1) / bpc + 1;
    endfunction

    function automatic logic [N*AW-1:0] chans(input int a0, input int a1, input int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    exp_t e1, e4;
    always @(negedge clk) begin
        if (reset_n) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done1: got done=1 want no pending op (cycle %0d)", cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("result_bpc1", res1, e1.res);
                    chk("err_bpc1", 32'(err1), 32'(e1.err));
                    chk("done_cycle_bpc1", cyc, e1.at);
                    chk("busy_at_done_bpc1", 32'(busy1), 32'd1);
                end
            end else if (err1) begin
                chk("err_without_done_bpc1", 32'(err1), 32'd0);
            end
            if (done4) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done4: got done=1 want no pending op (cycle %0d)", cyc);
                end else begin
                    e4 = q4.pop_front();
                    chk("result_bpc4", res4, e4.res);
                    chk("err_bpc4", 32'(err4), 32'(e4.err));
                    chk("done_cycle_bpc4", cyc, e4.at);
                end
            end else if (err4) begin
                chk("err_without_done_bpc4", 32'(err4), 32'd0);
            end
        end
    end

    // Waits until both units are idle, presents one request, pushes the
    // expected responses, then scrambles inputs to catch re-sampling.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] d,
                         input logic [N*AW-1:0] ch, input logic [SW-1:0] s);
        int n;
        int a;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((busy1 || busy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy after %0d cycles want idle", n);
        end
        op = o; data_in = d; amt_ch = ch; amt_sel = s; start = 1'b1;
        a = (int'(s) >= N) ? int'(ch[(N-1)*AW +: AW]) : int'(ch[int'(s)*AW +: AW]);
        if (o == 3'd0 || o >= 3'd6) a = 0;
        e.res = model(o, d, a);
        e.err = (o >= 3'd6);
        e.at  = cyc + lat(a, 1);
        q1.push_back(e);
        e.at  = cyc + lat(a, 4);
        q4.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); data_in = $urandom; amt_ch = N*AW'($urandom); amt_sel = SW'($urandom);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        chk("reset_err", 32'(err1), 32'd0);
        chk("reset_result", res1, 32'd0);
        chk("reset_result_bpc4", res4, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        // Directed cases
        issue(3'd1, 32'h0000_0001, chans(0, 4, 0), 2'd1);   // SLL by 4
        issue(3'd3, 32'h8000_0000, chans(31, 0, 0), 2'd0);  // SRA by 31
        issue(3'd2, 32'h8000_0000, chans(31, 0, 0), 2'd0);  // SRL by 31
        issue(3'd5, 32'h0000_00F1, chans(0, 0, 4), 2'd2);   // ROR by 4
        issue(3'd4, 32'h0000_00F1, chans(0, 0, 4), 2'd2);   // ROL by 4
        issue(3'd0, 32'h0000_00F1, chans(0, 0, 7), 2'd2);   // PASS
        issue(3'd7, 32'h0000_00F1, chans(5, 5, 5), 2'd2);   // illegal
        issue(3'd6, 32'h1234_5678, chans(9, 9, 9), 2'd0);   // illegal
        issue(3'd2, 32'hF000_0000, chans(10, 0, 0), 2'd0);  // SRL by 10 (BPC4: 4,4,2)
        issue(3'd1, 32'h0000_0003, chans(0, 0, 2), 2'd3);   // saturated select
        // Start pulsed while busy must be ignored.
        start = 1'b1; op = 3'd1; data_in = 32'hFFFF_FFFF; amt_ch = chans(1, 1, 1);
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of a 20-bit shift.
        issue(3'd1, 32'h0000_0001, chans(20, 0, 0), 2'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy1), 32'd0);
        chk("midreset_done", 32'(done1), 32'd0);
        chk("midreset_result", res1, 32'd0);
        chk("midreset_busy_bpc4", 32'(busy4), 32'd0);
        chk("midreset_result_bpc4", res4, 32'd0);
        q1.delete();
        q4.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        issue(3'd1, 32'h0000_0001, chans(1, 0, 0), 2'd0);

        // Random traffic, including back-to-back requests.
        repeat (150) begin
            issue(3'($urandom_range(0, 7)), $urandom, N*AW'($urandom), SW'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int n;
            n = 0;
            while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                total++; bad++;
                $display("FAIL drain_timeout: got %0d/%0d pending want 0", q1.size(), q4.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
